// File: rtl/ov7670_frame_capture.sv
// OV7670 RGB565 capture into a QVGA RGB444 frame buffer write port.
// Registers the camera pins once, tracks frame/line geometry and flags malformed frames.
module ov7670_frame_capture #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_LINES  = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_en,
    output logic        fb_we,
    output logic [16:0] fb_wAddr,
    output logic [11:0] fb_wdata,
    output logic        frame_done,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned XW = $clog2(H_PIXELS + 1);
    // Extra bit so lines beyond V_LINES still count and never alias back to V_LINES
    localparam int unsigned YW = $clog2(V_LINES + 1) + 1;

    localparam logic [XW-1:0] HMax   = XW'(H_PIXELS);
    localparam logic [YW-1:0] VMax   = YW'(V_LINES);
    localparam logic [16:0]   HStep  = 17'(H_PIXELS);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic          vs_q, vs_prev_q, hr_q, hr_prev_q;
    logic [7:0]    dat_q;
    logic [1:0]    state_q, state_d;
    logic          phase_q, phase_d;
    logic [6:0]    hi_q, hi_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [16:0]   base_q, base_d;
    logic          we_q, we_d;
    logic [16:0]   addr_q, addr_d;
    logic [11:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic vs_rise, vs_fall, hr_rise, hr_fall, phase_eff, pix_ok;

    assign vs_rise   = vs_q & ~vs_prev_q;
    assign vs_fall   = ~vs_q & vs_prev_q;
    assign hr_rise   = hr_q & ~hr_prev_q;
    assign hr_fall   = ~hr_q & hr_prev_q;
    // The first byte of a line is always a high byte, whatever phase was left over
    assign phase_eff = phase_q & ~hr_rise;
    assign pix_ok    = (x_q < HMax) && (y_q < VMax);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (vs_rise && capture_en) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (vs_fall) begin
                    state_d = StCapture;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    phase_d = 1'b0;
                end
            end
            StCapture: begin
                if (hr_q) begin
                    phase_d = ~phase_eff;
                    if (!phase_eff) begin
                        hi_d = {dat_q[7:4], dat_q[2:0]};
                    end else begin
                        if (pix_ok) begin
                            we_d    = 1'b1;
                            addr_d  = base_q + 17'(x_q);
                            wdata_d = {hi_q, dat_q[7], dat_q[4:1]};
                        end
                        if (x_q == HMax) begin
                            err_d = 1'b1;
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end else if (hr_fall) begin
                    if (phase_q) begin
                        err_d = 1'b1;
                    end
                    if (x_q != '0) begin
                        if (x_q != HMax) begin
                            err_d = 1'b1;
                        end
                        if (y_q != '1) begin
                            y_d = y_q + YW'(1);
                        end
                        // Base stops moving once writes are suppressed, so it cannot wrap
                        if (y_q < VMax) begin
                            base_d = base_q + HStep;
                        end
                    end
                    x_d     = '0;
                    phase_d = 1'b0;
                end
                if (vs_rise) begin
                    if (y_d != VMax) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StDone: begin
                state_d = capture_en ? StArm : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            hr_q      <= 1'b0;
            hr_prev_q <= 1'b0;
            dat_q     <= '0;
            state_q   <= StIdle;
            phase_q   <= 1'b0;
            hi_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            vs_q      <= cam_vsync;
            vs_prev_q <= vs_q;
            hr_q      <= cam_href;
            hr_prev_q <= hr_q;
            dat_q     <= cam_data;
            state_q   <= state_d;
            phase_q   <= phase_d;
            hi_q      <= hi_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign fb_we      = we_q;
    assign fb_wAddr   = addr_q;
    assign fb_wdata   = wdata_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture on a scaled 16x12 geometry.
// Drives camera frames at the negative edge and logs frame buffer writes for comparison.
module tb_ov7670_frame_capture;

    localparam int H = 16;
    localparam int V = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        capture_en = 1'b0;
    logic        fb_we;
    logic [16:0] fb_wAddr;
    logic [11:0] fb_wdata;
    logic        frame_done;
    logic        busy;
    logic        frame_err;

    ov7670_frame_capture #(
        .H_PIXELS(H),
        .V_LINES (V)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .capture_en(capture_en),
        .fb_we     (fb_we),
        .fb_wAddr  (fb_wAddr),
        .fb_wdata  (fb_wdata),
        .frame_done(frame_done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [16:0] wr_addr_log[$];
    logic [11:0] wr_data_log[$];
    int          wr_cyc_log[$];
    int          lo_cyc_log[$];
    int          done_cnt = 0;
    int          b2b_cnt = 0;
    bit          prev_we = 1'b0;

    int len[V];
    bit dng[V];
    bit use_dir = 1'b0;
    int en_drop = -1;
    int rst_line = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fb_we) begin
            wr_addr_log.push_back(fb_wAddr);
            wr_data_log.push_back(fb_wdata);
            wr_cyc_log.push_back(cyc);
        end
        if (fb_we && prev_we) b2b_cnt++;
        prev_we = fb_we;
        if (frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_hi(input int x, input int y);
        if (use_dir && y == 0 && x == 0) return 8'hF8;
        if (use_dir && y == 0 && x == 1) return 8'h07;
        return 8'(x * 37 + y * 11 + 5);
    endfunction

    function automatic logic [7:0] pix_lo(input int x, input int y);
        if (use_dir && y == 0 && x == 0) return 8'h1F;
        if (use_dir && y == 0 && x == 1) return 8'hE0;
        return 8'(x * 53 + y * 29 + 3);
    endfunction

    function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        return (wr_addr_log.size() > i) ? 32'(wr_addr_log[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (wr_data_log.size() > i) ? 32'(wr_data_log[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
        lo_cyc_log.delete();
        done_cnt = 0;
    endtask

    task automatic set_geometry();
        for (int y = 0; y < V; y++) begin
            len[y] = H;
            dng[y] = 1'b0;
        end
    endtask

    task automatic send_line(input int y);
        int nbytes;
        nbytes = 2 * len[y] + (dng[y] ? 1 : 0);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = (b % 2 == 1) ? pix_lo(b / 2, y) : pix_hi(b / 2, y);
            if (b % 2 == 1) lo_cyc_log.push_back(cyc);
            if (y == rst_line && b == len[y]) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_fb_we", 32'(fb_we), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_addr", 32'(fb_wAddr), 32'd0);
                @(negedge clk);
                reset_n = 1'b1;
                clear_logs();
            end
        end
        @(negedge clk);
        cam_href = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_lines();
        for (int y = 0; y < V; y++) begin
            if (y == en_drop) capture_en = 1'b0;
            send_line(y);
        end
    endtask

    task automatic frame_end(input string tag, input bit exp_done);
        cam_vsync = 1'b1;
        repeat (2) @(negedge clk);
        check_eq({tag, ".done_at_2"}, 32'(frame_done), 32'(exp_done));
        check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input bit lat_chk);
        logic [16:0] ea[$];
        logic [11:0] ed[$];
        int yy, base, ma, md, ml;
        bit err;
        yy = 0;
        base = 0;
        err = 1'b0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < len[y]; x++) begin
                if (x < H && yy < V) begin
                    ea.push_back(17'(base + x));
                    ed.push_back(conv(pix_hi(x, y), pix_lo(x, y)));
                end
            end
            if (len[y] > 0) begin
                yy++;
                base += H;
                if (len[y] != H) err = 1'b1;
            end
            if (dng[y]) err = 1'b1;
        end
        if (yy != V) err = 1'b1;
        check_eq({tag, ".count"}, 32'(wr_addr_log.size()), 32'(ea.size()));
        ma = 0;
        md = 0;
        for (int i = 0; i < ea.size() && i < wr_addr_log.size(); i++) begin
            if (wr_addr_log[i] !== ea[i]) ma++;
            if (wr_data_log[i] !== ed[i]) md++;
        end
        check_eq({tag, ".addr_mismatches"}, 32'(ma), 32'd0);
        check_eq({tag, ".data_mismatches"}, 32'(md), 32'd0);
        check_eq({tag, ".frame_err"}, 32'(frame_err), 32'(err));
        check_eq({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, ".back_to_back_we"}, 32'(b2b_cnt), 32'd0);
        if (lat_chk) begin
            ml = 0;
            for (int i = 0; i < wr_cyc_log.size() && i < lo_cyc_log.size(); i++) begin
                if (wr_cyc_log[i] != lo_cyc_log[i] + 2) ml++;
            end
            check_eq({tag, ".latency_mismatches"}, 32'(ml), 32'd0);
        end
    endtask

    initial begin
        int in_l5;
        set_geometry();
        repeat (3) @(negedge clk);
        check_eq("reset.fb_we", 32'(fb_we), 32'd0);
        check_eq("reset.fb_wAddr", 32'(fb_wAddr), 32'd0);
        check_eq("reset.fb_wdata", 32'(fb_wdata), 32'd0);
        check_eq("reset.frame_done", 32'(frame_done), 32'd0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        capture_en = 1'b1;
        repeat (2) @(negedge clk);

        // Full gradient frame
        clear_logs();
        frame_start();
        check_eq("A.busy_in_frame", 32'(busy), 32'd1);
        frame_lines();
        frame_end("A", 1'b1);
        check_frame("A", 1'b1);
        check_eq("A.last_addr", addr_at(H * V - 1), 32'(H * V - 1));

        // Directed colour conversion
        use_dir = 1'b1;
        clear_logs();
        frame_start();
        frame_lines();
        frame_end("B", 1'b1);
        check_frame("B", 1'b1);
        check_eq("B.pix0_data", data_at(0), 32'h0F0F);
        check_eq("B.pix1_data", data_at(1), 32'h00F0);
        use_dir = 1'b0;

        // Over-long line 5
        set_geometry();
        len[5] = H + 10;
        clear_logs();
        frame_start();
        frame_lines();
        frame_end("C", 1'b1);
        check_frame("C", 1'b0);
        check_eq("C.line6_start", addr_at(6 * H), 32'd96);
        in_l5 = 0;
        foreach (wr_addr_log[i]) if (wr_addr_log[i] >= 80 && wr_addr_log[i] < 96) in_l5++;
        check_eq("C.line5_writes", 32'(in_l5), 32'd16);
        check_eq("C.frame_err_hand", 32'(frame_err), 32'd1);

        // Short line 0 with dangling high byte
        set_geometry();
        len[0] = H - 4;
        dng[0] = 1'b1;
        clear_logs();
        frame_start();
        frame_lines();
        frame_end("D", 1'b1);
        check_frame("D", 1'b0);
        check_eq("D.count_hand", 32'(wr_addr_log.size()), 32'd188);
        check_eq("D.line1_start", addr_at(H - 4), 32'd16);

        // capture_en dropped mid-frame: this frame finishes, the next is ignored
        set_geometry();
        en_drop = 5;
        clear_logs();
        frame_start();
        frame_lines();
        frame_end("E", 1'b1);
        check_frame("E", 1'b0);
        check_eq("E.last_addr", addr_at(H * V - 1), 32'(H * V - 1));
        en_drop = -1;
        clear_logs();
        frame_start();
        check_eq("F.busy_in_frame", 32'(busy), 32'd0);
        frame_lines();
        frame_end("F", 1'b0);
        check_eq("F.count", 32'(wr_addr_log.size()), 32'd0);
        check_eq("F.done_pulses", 32'(done_cnt), 32'd0);

        // Reset pulsed mid-line 5
        capture_en = 1'b1;
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
        clear_logs();
        rst_line = 5;
        frame_start();
        frame_lines();
        rst_line = -1;
        frame_end("G", 1'b0);
        check_eq("G.writes_after_reset", 32'(wr_addr_log.size()), 32'd0);
        check_eq("G.done_pulses", 32'(done_cnt), 32'd0);
        check_eq("G.frame_err", 32'(frame_err), 32'd0);

        // Clean frame after the reset
        clear_logs();
        frame_start();
        frame_lines();
        frame_end("H", 1'b1);
        check_frame("H", 1'b1);
        check_eq("H.first_addr", addr_at(0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ov7670_frame_capture.md
# ov7670_frame_capture

Camera-side capture stage that feeds the QVGA frame buffer read by the VGA output path. It receives OV7670 RGB565 byte pairs on the camera pixel clock. It converts each pair to RGB444 and generates write-enable, address and data for the frame buffer's write port, one 320x240 frame at a time. It also reports frame completion and geometry errors.

## Interface
- H_PIXELS, 320: pixels written per line; excess pixels in a line are dropped.
- V_LINES, 240: lines written per frame; excess lines are dropped.
- clk  in  1  camera pixel clock (PCLK); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cam_vsync  in  1  high during inter-frame blanking; frame active while low.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  pixel bytes, high byte (R5,G3hi) first, then low byte (G3lo,B5).
- capture_en  in  1  level; permits starting a new frame.
- fb_we  out  1  frame buffer write strobe, one cycle per pixel.
- fb_wAddr  out  17  write address, y*H_PIXELS + x.
- fb_wdata  out  12  {R4,G4,B4}.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- busy  out  1  high from frame start to frame end.
- frame_err  out  1  sticky geometry error for the last or current frame.

## Operation
- Input stage: cam_vsync, cam_href and cam_data are registered once. All edge detection uses the registered copies.
- States:
  - IDLE: waits for a vsync rising edge while capture_en=1, then goes to ARM.
  - ARM: waits for vsync falling edge (frame start); clears x, y, line_base and frame_err; sets busy=1; goes to CAPTURE.
  - CAPTURE: processes lines; on vsync rising edge (frame end) goes to DONE.
  - DONE: pulses frame_done for one cycle and clears busy. Goes to ARM if capture_en=1, else IDLE.
- If capture_en falls mid-frame, the current frame completes normally.
- Byte phase: cleared on each href rising edge and toggled on every byte with href=1. Phase 0 latches the high byte; phase 1 emits a pixel.
- Conversion: R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]. Truncation only, no rounding.
- Write rule: a pixel is written only when x < H_PIXELS and y < V_LINES. fb_wAddr = line_base + x. x increments on every emitted pixel (saturating at H_PIXELS).
- Href falling edge ends a line:
  - if x > 0, then y increments and line_base += H_PIXELS;
  - x is cleared.
  - Lines with zero pixels do not count.
- frame_err is set when any of the following occurs:
  - a line ends with x ≠ H_PIXELS (an over-long line also sets it, detected when a pixel arrives with x = H_PIXELS);
  - href falls at phase 1 (dangling high byte, which is discarded);
  - vsync rises with y ≠ V_LINES.
- Short lines leave their remaining addresses unwritten. The next line still starts at line_base + H_PIXELS.
- Address arithmetic is 17-bit; the maximum written address is H_PIXELS*V_LINES-1 (76799). No address wrap ever occurs because writes past V_LINES are suppressed.
- Href activity outside CAPTURE is ignored.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - fb_we=0, fb_wAddr=0, fb_wdata=0;
  - frame_done=0, busy=0, frame_err=0;
  - state=IDLE, phase=0, x=y=line_base=0.
- Latency: a low byte present on cam_data before edge k produces fb_we=1 with matching fb_wAddr and fb_wdata after edge k+1 (2 cycles). All outputs are registered.
- fb_we is high for exactly 1 cycle per pixel; at most every other cycle.
- frame_done rises 2 cycles after the pin-level vsync rising edge (input register plus state register). busy falls in the same cycle.
- If vsync rises while a pixel write is pending in the pipeline, that write still completes before frame_done.
- Reset mid-frame: outputs clear immediately. No writes occur until a full IDLE→ARM→CAPTURE sequence (a new vsync rising then falling edge) completes.

## Test plan
- Reset, capture_en=1, one 320x240 frame of RGB565 gradient -> exactly 76800 fb_we pulses, addresses 0..76799 in order, one frame_done, frame_err=0.
- Byte pairs (0xF8,0x1F) then (0x07,0xE0) -> fb_wdata 0xF0F then 0x0F0, 2 cycles after each low byte.
- Line 5 carries 330 pixels -> 320 writes for that line, line 6 starts at address 1920, frame_err=1 after frame_done.
- Line 0 carries 300 pixels plus a dangling odd byte -> 300 writes, line 1 starts at 320, frame_err=1, no write for the odd byte.
- capture_en dropped at line 100 -> frame finishes to address 76799 with frame_done; next frame produces no fb_we, busy stays 0.
- reset_n pulsed low mid-line 50 -> fb_we, busy and fb_wAddr go 0 immediately; remaining bytes of that frame produce no writes; the following frame captures normally from address 0.
